// File: rtl/aes_apb_block_feeder.sv
// -----------------------------------------------------------------------------
// aes_apb_block_feeder
//
// APB master that pushes one 128-bit block at a time through the CBC AES APB
// slave sitting on the same APB segment. One block plus its mode is accepted
// on a valid/ready input. The block then goes through these steps:
//   - its four words are written into the data-in bank selected by the mode;
//   - the start bit is pulsed (set, then cleared);
//   - after a settle interval, status is polled until the done bit is seen;
//   - the four output words are read back;
//   - the result is presented on a valid/ready output.
// Keys and IVs are loaded by the CPU beforehand; this block never touches them.
//
// Optional feature macro: AES_FEEDER_TIMEOUT_EN
//   defined   : status polling gives up after POLL_MAX reads without done,
//               raises the sticky timeout_err flag and returns to IDLE.
//   undefined : polling waits forever and timeout_err is tied low.
//
// Parameters
//   BASE_ADDR      byte base address of the AES slave
//   SETTLE_CYCLES  idle cycles after the control clear, before the first poll
//   POLL_MAX       status reads before timeout (timeout build only)
//
// Ports
//   vclk, vrst           clock, asynchronous active-high reset
//   s_valid/s_ready      input block handshake
//   s_data, s_mode       input block ([127:96] = word 0), 0=encrypt 1=decrypt
//   m_valid/m_ready      result handshake
//   m_data, m_mode       result block ([127:96] = word 0) and its mode
//   vpsel_o, vpenable_o  APB select / enable
//   vpaddr_o, vpwrite_o  APB byte address / write strobe
//   vpwdata_o, vprdata_i APB write / read data
//   busy                 high whenever the FSM is not idle
//   timeout_err          sticky poll-timeout flag
// -----------------------------------------------------------------------------
module aes_apb_block_feeder #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int          SETTLE_CYCLES = 8,
    parameter int          POLL_MAX      = 4096
) (
    input  logic         vclk,
    input  logic         vrst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data,
    input  logic         s_mode,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic         m_mode,
    output logic         vpsel_o,
    output logic         vpenable_o,
    output logic [31:0]  vpaddr_o,
    output logic         vpwrite_o,
    output logic [31:0]  vpwdata_o,
    input  logic [31:0]  vprdata_i,
    output logic         busy,
    output logic         timeout_err
);

    localparam logic [31:0] OFS_DIN  = 32'h0000_0020;
    localparam logic [31:0] OFS_DOUT = 32'h0000_0060;
    localparam logic [31:0] OFS_CTRL = 32'h0000_0080;
    localparam logic [31:0] OFS_STAT = 32'h0000_0084;

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_SET  = 3'd2,
        ST_WR_CLR  = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_POLL    = 3'd5,
        ST_RD_OUT  = 3'd6,
        ST_OUT     = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next;

    // r_phase: 0 = APB SETUP cycle, 1 = APB ACCESS cycle of the current transfer
    logic                r_phase;
    logic [1:0]          r_word;
    logic                r_mode;
    logic [127:0]        r_block;
    logic [127:0]        r_result;
    logic [SETTLE_W-1:0] r_settle_cnt;
    // r_alive keeps s_ready low while reset is held and for the first edge after it
    logic                r_alive;

    logic                w_apb_state;
    logic                w_accept;
    logic                w_done;
    logic                w_settle_last;
    logic                w_poll_last;
    logic [31:0]         w_bank_ofs;
    logic [31:0]         w_word_ofs;

    // Word i of a block; word 0 is the most significant 32 bits.
    function automatic logic [31:0] block_word(input logic [127:0] blk,
                                               input logic [1:0]   idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

    assign w_apb_state = (r_state == ST_WR_DATA) || (r_state == ST_WR_SET) ||
                         (r_state == ST_WR_CLR)  || (r_state == ST_POLL)   ||
                         (r_state == ST_RD_OUT);
    assign w_accept      = (r_state == ST_IDLE) && s_valid && r_alive;
    assign w_done        = r_mode ? vprdata_i[1] : vprdata_i[0];
    assign w_settle_last = (r_settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
    assign w_bank_ofs    = {27'd0, r_mode, 4'd0};
    assign w_word_ofs    = {28'd0, r_word, 2'd0};

`ifdef AES_FEEDER_TIMEOUT_EN
    localparam int POLL_W = $clog2(POLL_MAX + 1);

    logic [POLL_W-1:0] r_poll_cnt;
    logic              r_timeout;

    // Poll counter holds at POLL_MAX rather than wrapping.
    function automatic logic [POLL_W-1:0] poll_sat_inc(input logic [POLL_W-1:0] cnt);
        return (cnt >= POLL_W'(POLL_MAX)) ? cnt : cnt + POLL_W'(1);
    endfunction

    assign w_poll_last = (r_poll_cnt == POLL_W'(POLL_MAX - 1));
    assign timeout_err = r_timeout;

    always_ff @(posedge vclk or posedge vrst) begin
        if (vrst) begin
            r_poll_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (r_state == ST_SETTLE) begin
                r_poll_cnt <= '0;
            end else if ((r_state == ST_POLL) && r_phase) begin
                r_poll_cnt <= poll_sat_inc(r_poll_cnt);
            end
            if ((r_state == ST_POLL) && r_phase && !w_done && w_poll_last) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    // No poll limit in this build; the parameter is kept for a uniform interface.
    logic w_unused_poll_max;
    assign w_unused_poll_max = (POLL_MAX != 0);
    assign w_poll_last       = 1'b0;
    assign timeout_err       = 1'b0;
`endif

    // State register
    always_ff @(posedge vclk or posedge vrst) begin
        if (vrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; every APB state leaves only at the end of an ACCESS cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (r_phase && (r_word == 2'd3)) begin
                    w_next = ST_WR_SET;
                end
            end
            ST_WR_SET: begin
                if (r_phase) begin
                    w_next = ST_WR_CLR;
                end
            end
            ST_WR_CLR: begin
                if (r_phase) begin
                    w_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_settle_last) begin
                    w_next = ST_POLL;
                end
            end
            ST_POLL: begin
                if (r_phase) begin
                    if (w_done) begin
                        w_next = ST_RD_OUT;
                    end else if (w_poll_last) begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_RD_OUT: begin
                if (r_phase && (r_word == 2'd3)) begin
                    w_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Output decode; bus outputs are driven from state so reset clears them at once
    always_comb begin
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        vpsel_o    = 1'b0;
        vpenable_o = 1'b0;
        vpaddr_o   = 32'd0;
        vpwrite_o  = 1'b0;
        vpwdata_o  = 32'd0;
        busy       = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                s_ready = r_alive;
            end
            ST_WR_DATA: begin
                vpsel_o    = 1'b1;
                vpenable_o = r_phase;
                vpwrite_o  = 1'b1;
                vpaddr_o   = BASE_ADDR + OFS_DIN + w_bank_ofs + w_word_ofs;
                vpwdata_o  = block_word(r_block, r_word);
            end
            ST_WR_SET: begin
                vpsel_o    = 1'b1;
                vpenable_o = r_phase;
                vpwrite_o  = 1'b1;
                vpaddr_o   = BASE_ADDR + OFS_CTRL;
                vpwdata_o  = r_mode ? 32'd2 : 32'd1;
            end
            ST_WR_CLR: begin
                // The slave starts on a 0->1 edge of its start bit, so the clear is required.
                vpsel_o    = 1'b1;
                vpenable_o = r_phase;
                vpwrite_o  = 1'b1;
                vpaddr_o   = BASE_ADDR + OFS_CTRL;
            end
            ST_POLL: begin
                vpsel_o    = 1'b1;
                vpenable_o = r_phase;
                vpaddr_o   = BASE_ADDR + OFS_STAT;
            end
            ST_RD_OUT: begin
                vpsel_o    = 1'b1;
                vpenable_o = r_phase;
                vpaddr_o   = BASE_ADDR + OFS_DOUT + w_bank_ofs + w_word_ofs;
            end
            ST_OUT: begin
                m_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Control counters, latched mode and the result register
    always_ff @(posedge vclk or posedge vrst) begin
        if (vrst) begin
            r_phase      <= 1'b0;
            r_word       <= 2'd0;
            r_mode       <= 1'b0;
            r_settle_cnt <= '0;
            r_alive      <= 1'b0;
            r_result     <= 128'd0;
        end else begin
            r_alive <= 1'b1;

            if (w_apb_state) begin
                r_phase <= ~r_phase;
            end else begin
                r_phase <= 1'b0;
            end

            if (w_accept) begin
                r_mode <= s_mode;
            end

            // Wraps 3->0 on the last ACCESS, which is also the state exit.
            if (((r_state == ST_WR_DATA) || (r_state == ST_RD_OUT)) && r_phase) begin
                r_word <= r_word + 2'd1;
            end

            // The stale done bit of the previous block clears during this wait.
            if (r_state == ST_SETTLE) begin
                r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
            end else begin
                r_settle_cnt <= '0;
            end

            if ((r_state == ST_RD_OUT) && r_phase) begin
                case (r_word)
                    2'd0:    r_result[127:96] <= vprdata_i;
                    2'd1:    r_result[95:64]  <= vprdata_i;
                    2'd2:    r_result[63:32]  <= vprdata_i;
                    default: r_result[31:0]   <= vprdata_i;
                endcase
            end
        end
    end

    // Input block capture; data path only, no reset needed
    always_ff @(posedge vclk) begin
        if (w_accept) begin
            r_block <= s_data;
        end
    end

    assign m_data = r_result;
    assign m_mode = r_mode;

endmodule

// File: tb/tb_aes_apb_block_feeder.sv
module tb_aes_apb_block_feeder;

`ifdef AES_FEEDER_TIMEOUT_EN
    localparam int TB_POLL_MAX = 4;
`else
    localparam int TB_POLL_MAX = 4096;
`endif

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         vrst;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         s_mode;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic         m_mode;
    logic         vpsel_o;
    logic         vpenable_o;
    logic [31:0]  vpaddr_o;
    logic         vpwrite_o;
    logic [31:0]  vpwdata_o;
    logic [31:0]  vprdata;
    logic         busy;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;

    aes_apb_block_feeder #(
        .BASE_ADDR     (32'h0000_0000),
        .SETTLE_CYCLES (8),
        .POLL_MAX      (TB_POLL_MAX)
    ) dut (
        .vclk        (clk),
        .vrst        (vrst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_mode      (s_mode),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_mode      (m_mode),
        .vpsel_o     (vpsel_o),
        .vpenable_o  (vpenable_o),
        .vpaddr_o    (vpaddr_o),
        .vpwrite_o   (vpwrite_o),
        .vpwdata_o   (vpwdata_o),
        .vprdata_i   (vprdata),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_of(input logic [127:0] b, input int i);
        return b[127-32*i -: 32];
    endfunction

    // Stand-in cipher: both directions XOR with PT^CT, so the reference
    // vector encrypts to CT and CT decrypts back to PT.
    function automatic logic [127:0] cipher(input logic [127:0] b);
        logic [127:0] m;
        m = PT ^ CT;
        return b ^ m;
    endfunction

    // ---------------- AES slave stub ----------------
    logic [31:0] st_din  [2][4];
    logic [31:0] st_dout [2][4];
    logic [31:0] st_ctrl;
    logic [1:0]  st_status;
    logic        st_run;
    logic        st_rmode;
    int          st_cnt;
    int          stub_delay;
    logic        stub_stuck;

    initial begin
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) begin
                st_din[b][i]  = 32'd0;
                st_dout[b][i] = 32'd0;
            end
        end
        st_ctrl    = 32'd0;
        st_status  = 2'b00;
        st_run     = 1'b0;
        st_rmode   = 1'b0;
        st_cnt     = 0;
        stub_delay = 3;
        stub_stuck = 1'b0;
    end

    always @(posedge clk) begin
        if (st_run) begin
            if (st_cnt == 0) begin
                for (int i = 0; i < 4; i++) begin
                    st_dout[st_rmode][i] <= word_of(cipher({st_din[st_rmode][0], st_din[st_rmode][1],
                                                            st_din[st_rmode][2], st_din[st_rmode][3]}), i);
                end
                if (!stub_stuck) st_status[st_rmode] <= 1'b1;
                st_run <= 1'b0;
            end else begin
                st_cnt <= st_cnt - 1;
            end
        end
        if (vpsel_o && vpenable_o && vpwrite_o) begin
            if (vpaddr_o >= 32'h20 && vpaddr_o < 32'h40) begin
                st_din[vpaddr_o[4]][vpaddr_o[3:2]] <= vpwdata_o;
            end else if (vpaddr_o == 32'h80) begin
                for (int m = 0; m < 2; m++) begin
                    if (vpwdata_o[m] && !st_ctrl[m]) begin
                        st_run       <= 1'b1;
                        st_cnt       <= stub_delay;
                        st_rmode     <= m[0];
                        st_status[m] <= 1'b0;
                    end
                end
                st_ctrl <= vpwdata_o;
            end
        end
    end

    always_comb begin
        vprdata = 32'd0;
        if (vpsel_o && !vpwrite_o) begin
            if (vpaddr_o == 32'h84) vprdata = {30'd0, st_status};
            else if (vpaddr_o >= 32'h60 && vpaddr_o < 32'h80) vprdata = st_dout[vpaddr_o[4]][vpaddr_o[3:2]];
        end
    end

    // ---------------- APB monitor ----------------
    logic [31:0] mon_addr [$];
    logic        mon_wr   [$];
    logic [31:0] mon_dat  [$];
    int          prot_err = 0;
    logic        prev_setup = 1'b0;
    logic [31:0] su_addr, su_wdata;
    logic        su_wr;

    always @(negedge clk) begin
        if (vrst) begin
            prev_setup = 1'b0;
        end else if (!vpsel_o) begin
            if (vpenable_o || vpwrite_o || vpaddr_o != 32'd0 || vpwdata_o != 32'd0) prot_err++;
            prev_setup = 1'b0;
        end else if (!vpenable_o) begin
            su_addr    = vpaddr_o;
            su_wr      = vpwrite_o;
            su_wdata   = vpwdata_o;
            prev_setup = 1'b1;
        end else begin
            if (!prev_setup || su_addr != vpaddr_o || su_wr != vpwrite_o || su_wdata != vpwdata_o) prot_err++;
            mon_addr.push_back(vpaddr_o);
            mon_wr.push_back(vpwrite_o);
            mon_dat.push_back(vpwrite_o ? vpwdata_o : vprdata);
            prev_setup = 1'b0;
        end
    end

    function automatic int count_polls();
        int n = 0;
        for (int i = 0; i < mon_addr.size(); i++) begin
            if (mon_addr[i] == 32'h84 && !mon_wr[i]) n++;
        end
        return n;
    endfunction

    // ---------------- scoreboard ----------------
    logic [127:0] exp_data [$];
    logic         exp_mode [$];

    task automatic run_block(input logic [127:0] d, input logic md, input int hold,
                             output int lat, output int npoll);
        int wc;
        logic [127:0] held;
        mon_addr.delete(); mon_wr.delete(); mon_dat.delete();
        s_data = d; s_mode = md; s_valid = 1'b1;
        wc = 0;
        while (!s_ready && wc < 200) begin @(posedge clk); #1; wc++; end
        checks++;
        if (!s_ready) begin errors++; $display("FAIL accept: s_ready=%0b required 1", s_ready); end
        @(posedge clk); #1;
        s_valid = 1'b0;
        exp_data.push_back(cipher(d));
        exp_mode.push_back(md);
        lat = 0;
        while (!m_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
        checks++;
        if (!m_valid) begin errors++; $display("FAIL result_timeout: m_valid=%0b required 1", m_valid); end
        held = m_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checks++;
            if (m_valid !== 1'b1 || m_data !== held || vpsel_o !== 1'b0 || s_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall cyc%0d: m_valid=%0b m_data=%h psel=%0b s_ready=%0b required 1 %h 0 0",
                         h, m_valid, m_data, vpsel_o, s_ready, held);
            end
        end
        if (exp_data.size() > 0) begin
            logic [127:0] ed;
            logic         em;
            ed = exp_data.pop_front();
            em = exp_mode.pop_front();
            checks++;
            if (m_data !== ed || m_mode !== em) begin
                errors++;
                $display("FAIL result: m_data=%h m_mode=%0b required %h %0b", m_data, m_mode, ed, em);
            end
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: s_ready=%0b m_valid=%0b required 1 0", s_ready, m_valid);
        end
        npoll = count_polls();
    endtask

    task automatic check_latency(input string nm, input int lat, input int npoll);
        checks++;
        if (npoll < 1 || lat !== 28 + 2 * npoll) begin
            errors++;
            $display("FAIL latency_%s: %0d cycles with %0d polls, required %0d", nm, lat, npoll, 28 + 2 * npoll);
        end
    endtask

    task automatic check_apb_seq(input logic [127:0] d, input logic md);
        int n, k;
        n = mon_addr.size();
        checks++;
        if (n < 11) begin
            errors++;
            $display("FAIL apb_count: %0d transfers, required at least 11", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (mon_wr[i] !== 1'b1 || mon_addr[i] !== 32'h20 + 32'(16 * md) + 32'(4 * i) ||
                    mon_dat[i] !== word_of(d, i)) begin
                    errors++;
                    $display("FAIL apb_din%0d: wr=%0b addr=%h data=%h required 1 %h %h", i, mon_wr[i],
                             mon_addr[i], mon_dat[i], 32'h20 + 32'(16 * md) + 32'(4 * i), word_of(d, i));
                end
            end
            checks++;
            if (mon_wr[4] !== 1'b1 || mon_addr[4] !== 32'h80 || mon_dat[4] !== (md ? 32'd2 : 32'd1)) begin
                errors++;
                $display("FAIL apb_set: wr=%0b addr=%h data=%h required 1 80 %0d", mon_wr[4], mon_addr[4],
                         mon_dat[4], md ? 2 : 1);
            end
            checks++;
            if (mon_wr[5] !== 1'b1 || mon_addr[5] !== 32'h80 || mon_dat[5] !== 32'd0) begin
                errors++;
                $display("FAIL apb_clr: wr=%0b addr=%h data=%h required 1 80 0", mon_wr[5], mon_addr[5], mon_dat[5]);
            end
            k = 6;
            while (k < n && mon_addr[k] == 32'h84 && !mon_wr[k]) k++;
            checks++;
            if (k == 6 || n !== k + 4) begin
                errors++;
                $display("FAIL apb_polls: polls=%0d total=%0d required >=1 polls and total=polls+10", k - 6, n);
            end else begin
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (mon_wr[k+i] !== 1'b0 || mon_addr[k+i] !== 32'h60 + 32'(16 * md) + 32'(4 * i) ||
                        mon_dat[k+i] !== word_of(cipher(d), i)) begin
                        errors++;
                        $display("FAIL apb_dout%0d: wr=%0b addr=%h data=%h required 0 %h %h", i, mon_wr[k+i],
                                 mon_addr[k+i], mon_dat[k+i], 32'h60 + 32'(16 * md) + 32'(4 * i),
                                 word_of(cipher(d), i));
                    end
                end
            end
        end
        checks++;
        if (prot_err !== 0) begin
            errors++;
            $display("FAIL apb_protocol: %0d violations, required 0", prot_err);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || vpsel_o !== 1'b0 || vpenable_o !== 1'b0 ||
            vpaddr_o !== 32'd0 || vpwrite_o !== 1'b0 || vpwdata_o !== 32'd0 || busy !== 1'b0 ||
            m_data !== 128'd0 || m_mode !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: s_ready=%0b m_valid=%0b psel=%0b pen=%0b addr=%h busy=%0b m_data=%h required all 0",
                     s_ready, m_valid, vpsel_o, vpenable_o, vpaddr_o, busy, m_data);
        end
        vrst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: s_ready=%0b busy=%0b required 1 0", s_ready, busy);
        end
    endtask

    task automatic test_encrypt();
        int lat, np;
        run_block(PT, 1'b0, 0, lat, np);
        check_latency("encrypt", lat, np);
        check_apb_seq(PT, 1'b0);
    endtask

    task automatic test_decrypt();
        int lat, np;
        run_block(CT, 1'b1, 0, lat, np);
        check_latency("decrypt", lat, np);
        check_apb_seq(CT, 1'b1);
    endtask

    task automatic test_stall();
        int lat, np;
        run_block(128'hdeadbeef_01234567_89abcdef_0badf00d, 1'b0, 50, lat, np);
        check_latency("stall", lat, np);
    endtask

    task automatic test_extra_polls();
        int lat, np;
        stub_delay = 12;
        run_block(128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, 1'b1, 0, lat, np);
        checks++;
        if (np < 2) begin
            errors++;
            $display("FAIL extra_polls: %0d polls, required at least 2", np);
        end
        check_latency("extra_polls", lat, np);
        stub_delay = 3;
    endtask

    task automatic test_back_to_back();
        int lat, np;
        logic [127:0] d;
        for (int b = 0; b < 4; b++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_block(d, $urandom_range(0, 1) == 1, 0, lat, np);
            check_latency("b2b", lat, np);
        end
    endtask

    task automatic test_reset_mid();
        int wc, lat, np;
        s_data = 128'hcafef00d_11112222_33334444_55556666; s_mode = 1'b0; s_valid = 1'b1;
        wc = 0;
        while (!s_ready && wc < 200) begin @(posedge clk); #1; wc++; end
        @(posedge clk); #1;
        s_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (vpsel_o !== 1'b1 || vpenable_o !== 1'b0 || vpaddr_o !== 32'h28) begin
            errors++;
            $display("FAIL word2_setup: psel=%0b pen=%0b addr=%h required 1 0 28", vpsel_o, vpenable_o, vpaddr_o);
        end
        vrst = 1'b1;
        #1;
        checks++;
        if (vpsel_o !== 1'b0 || vpenable_o !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: psel=%0b pen=%0b m_valid=%0b busy=%0b required 0 0 0 0",
                     vpsel_o, vpenable_o, m_valid, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        vrst = 1'b0;
        @(posedge clk); #1;
        run_block(128'h99887766_55443322_11000000_abcdef01, 1'b0, 0, lat, np);
        check_latency("after_reset", lat, np);
        check_apb_seq(128'h99887766_55443322_11000000_abcdef01, 1'b0);
    endtask

`ifdef AES_FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        int wc;
        logic saw_valid;
        stub_stuck = 1'b1;
        mon_addr.delete(); mon_wr.delete(); mon_dat.delete();
        s_data = PT; s_mode = 1'b0; s_valid = 1'b1;
        wc = 0;
        while (!s_ready && wc < 200) begin @(posedge clk); #1; wc++; end
        @(posedge clk); #1;
        s_valid = 1'b0;
        saw_valid = 1'b0;
        wc = 0;
        while (busy && wc < 500) begin
            @(posedge clk); #1;
            if (m_valid) saw_valid = 1'b1;
            wc++;
        end
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b1 || saw_valid !== 1'b0 || count_polls() !== 4) begin
            errors++;
            $display("FAIL timeout: busy=%0b timeout_err=%0b m_valid_seen=%0b polls=%0d required 0 1 0 4",
                     busy, timeout_err, saw_valid, count_polls());
        end
        stub_stuck = 1'b0;
    endtask
`endif

    task automatic test_no_timeout_flag();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag: timeout_err=%0b required 0", timeout_err);
        end
    endtask

    initial begin
        vrst    = 1'b1;
        s_valid = 1'b0;
        s_data  = 128'd0;
        s_mode  = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_stall();
        test_extra_polls();
        test_back_to_back();
        test_reset_mid();
        test_no_timeout_flag();
`ifdef AES_FEEDER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
